// File: rtl/inst_dispatch_n_pkg.sv
// Shared types and sizing for the N-wide dispatch stage.
// Holds the rename-lane, issue-bus and ROB-entry layouts, the pointer widths
// (with wrap bit) and the writeback-wakeup match helper.
package inst_dispatch_n_pkg;

   localparam int WIDTH     = 2;
   localparam int ROB_DEPTH = 16;
   localparam int SQ_DEPTH  = 16;
   localparam int WB_PORTS  = 2;
   localparam int PREG_W    = 6;

   localparam int ROB_PTR_W = $clog2(ROB_DEPTH) + 1;
   localparam int SQ_PTR_W  = $clog2(SQ_DEPTH) + 1;
   localparam int CNT_W     = $clog2(WIDTH) + 1;
   localparam int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef logic [PREG_W-1:0]    reg_addr_t;
   typedef logic [ROB_PTR_W-1:0] rob_ptr_t;
   typedef logic [SQ_PTR_W-1:0]  sq_ptr_t;
   typedef logic [ROB_PTR_W-2:0] rob_idx_t;
   typedef logic [SQ_PTR_W-2:0]  sq_idx_t;

   typedef enum logic [1:0] {
      Inst_Invalid  = 2'd0,
      Inst_Wait     = 2'd1,
      Inst_Complete = 2'd2
   } inst_state_e;

   typedef struct packed {
      logic        ex;
      logic [4:0]  code;
   } exception_t;

   typedef struct packed {
      logic [31:0] raw;
      logic        rf_we;
      logic [4:0]  dest;
   } inst_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      inst_t       inst;
      reg_addr_t   phy_dest;
      reg_addr_t   phy_src1;
      reg_addr_t   phy_src2;
      logic        src1_ready;
      logic        src2_ready;
      reg_addr_t   old_dest;
      logic        is_store_op;
      logic        is_movc;
      logic        is_priv;
      logic        is_eret;
      logic        br_taken;
      logic [3:0]  bpu_entry;
      exception_t  exception;
   } rename_lane_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      inst_t       inst;
      reg_addr_t   phy_dest;
      reg_addr_t   phy_src1;
      reg_addr_t   phy_src2;
      logic        src1_ready;
      logic        src2_ready;
      rob_idx_t    rob_entry_num;
      sq_idx_t     store_num;
      sq_idx_t     pre_store;
      logic        pre_store_ready;
      logic        is_store_op;
      logic        is_movc;
      logic        is_priv;
      logic        is_eret;
      logic        br_taken;
      logic [3:0]  bpu_entry;
   } decode_to_issue_bus_t;

   typedef struct packed {
      inst_state_e state;
      logic [31:0] pc;
      logic [4:0]  dest;
      reg_addr_t   phy_dest;
      reg_addr_t   old_dest;
      logic        is_store_op;
      logic        is_priv;
      logic        is_eret;
      logic        br_taken;
      logic [3:0]  bpu_entry;
      exception_t  exception;
      logic [31:0] verify_result;
   } rob_entry_t;

   // True when any valid writeback port names this physical register.
   // Register 0 is the hard-wired ready register and is never woken.
   function automatic logic wake_hit(input reg_addr_t                 preg,
                                     input logic [WB_PORTS-1:0]       wb_v,
                                     input reg_addr_t [WB_PORTS-1:0]  wb_p);
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < WB_PORTS; j++) begin
         hit = hit | (wb_v[j] && (wb_p[j] == preg) && (preg != '0));
      end
      return hit;
   endfunction

endpackage

// File: rtl/inst_dispatch_n_dispatch_compact.sv
// Combinational compaction network for a dispatch group.
// Inputs : valid_i / store_i   per rename lane.
// Outputs: src_idx_o[k]  rename lane feeding output lane k
//          occ_o[k]      output lane k is occupied (k < n)
//          st_pre_o[k]   older valid stores ahead of output lane k
//          n_o / s_o     valid-lane and valid-store counts for the group
module dispatch_compact
   import inst_dispatch_n_pkg::*;
(
   input  logic [WIDTH-1:0]            valid_i,
   input  logic [WIDTH-1:0]            store_i,
   output logic [WIDTH-1:0][IDX_W-1:0] src_idx_o,
   output logic [WIDTH-1:0]            occ_o,
   output logic [WIDTH-1:0][CNT_W-1:0] st_pre_o,
   output logic [CNT_W-1:0]            n_o,
   output logic [CNT_W-1:0]            s_o
);

   logic [WIDTH-1:0][CNT_W-1:0] vpre_s;
   logic [WIDTH-1:0][CNT_W-1:0] spre_s;

   // Exclusive prefix counts of valid lanes and valid stores per input lane
   always_comb begin
      logic [CNT_W-1:0] vc;
      logic [CNT_W-1:0] sc;
      vc = '0;
      sc = '0;
      for (int i = 0; i < WIDTH; i++) begin
         vpre_s[i] = vc;
         spre_s[i] = sc;
         vc = vc + (valid_i[i] ? CNT_W'(1) : CNT_W'(0));
         sc = sc + ((valid_i[i] && store_i[i]) ? CNT_W'(1) : CNT_W'(0));
      end
      n_o = vc;
      s_o = sc;
   end

   // Output lane k takes the valid input lane whose valid prefix equals k
   always_comb begin
      for (int k = 0; k < WIDTH; k++) begin
         src_idx_o[k] = '0;
         occ_o[k]     = 1'b0;
         st_pre_o[k]  = '0;
         for (int i = 0; i < WIDTH; i++) begin
            logic hit;
            hit          = valid_i[i] && (vpre_s[i] == CNT_W'(k));
            src_idx_o[k] = hit ? IDX_W'(i) : src_idx_o[k];
            occ_o[k]     = hit ? 1'b1      : occ_o[k];
            st_pre_o[k]  = hit ? spre_s[i] : st_pre_o[k];
         end
      end
   end

endmodule

// File: rtl/inst_dispatch_n.sv
// N-wide registered dispatch stage between rename and issue queue / ROB.
// Compacts valid lanes, allocates ROB and store-queue numbers from its own
// speculative tails, checks capacity for the whole group, holds the group
// under back-pressure while snooping writeback wakeups, restores tails on flush.
// Ports: clk/reset (sync, active-high); flush + flush_*_tail restore values;
//        rob_head/store_head committed heads with wrap bit;
//        in_valid/in_ready/in_lane rename handshake; wb_valid/wb_preg wakeups;
//        out_valid/out_accept output handshake; decode_to_issue_bus,
//        map_to_rob_bus, out_cnt registered group outputs.
module inst_dispatch_n
   import inst_dispatch_n_pkg::*;
(
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               flush,
   input  rob_ptr_t                           flush_rob_tail,
   input  sq_ptr_t                            flush_store_tail,
   input  rob_ptr_t                           rob_head,
   input  sq_ptr_t                            store_head,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  rename_lane_t [WIDTH-1:0]           in_lane,
   input  logic [WB_PORTS-1:0]                wb_valid,
   input  reg_addr_t [WB_PORTS-1:0]           wb_preg,
   output logic                               out_valid,
   input  logic                               out_accept,
   output decode_to_issue_bus_t [WIDTH-1:0]   decode_to_issue_bus,
   output rob_entry_t [WIDTH-1:0]             map_to_rob_bus,
   output logic [CNT_W-1:0]                   out_cnt
);

   localparam int RN_W = ROB_PTR_W + 1;
   localparam int SN_W = SQ_PTR_W + 1;

   rob_ptr_t                         rob_tail_q, rob_tail_d;
   sq_ptr_t                          store_tail_q, store_tail_d;
   logic                             out_valid_q, out_valid_d;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   decode_to_issue_bus_t [WIDTH-1:0] d2i_q, d2i_d, d2i_new_s;
   rob_entry_t [WIDTH-1:0]           rob_q, rob_d, rob_new_s;

   logic [WIDTH-1:0]            lane_v_s, lane_st_s, occ_s;
   logic [WIDTH-1:0][IDX_W-1:0] src_idx_s;
   logic [WIDTH-1:0][CNT_W-1:0] st_pre_s;
   logic [CNT_W-1:0]            n_s, s_s;
   rob_ptr_t                    rob_occ_s;
   sq_ptr_t                     sq_occ_s;
   logic                        room_s, accept_s;

   // Per-lane valid and store flags for the compaction network
   always_comb begin
      for (int i = 0; i < WIDTH; i++) begin
         lane_v_s[i]  = in_lane[i].valid;
         lane_st_s[i] = in_lane[i].is_store_op;
      end
   end

   dispatch_compact u_compact (
      .valid_i   (lane_v_s),
      .store_i   (lane_st_s),
      .src_idx_o (src_idx_s),
      .occ_o     (occ_s),
      .st_pre_o  (st_pre_s),
      .n_o       (n_s),
      .s_o       (s_s)
   );

   // Whole-group capacity check; occupancy subtraction wraps with the pointer width
   always_comb begin
      rob_occ_s = rob_tail_q - rob_head;
      sq_occ_s  = store_tail_q - store_head;
      room_s    = (({1'b0, rob_occ_s} + RN_W'(n_s)) <= RN_W'(ROB_DEPTH)) &&
                  (({1'b0, sq_occ_s}  + SN_W'(s_s)) <= SN_W'(SQ_DEPTH));
      in_ready  = !flush && room_s && (!out_valid_q || out_accept);
      accept_s  = in_valid && in_ready;
   end

   // Build the compacted group with allocated numbers and incoming wakeups
   always_comb begin
      logic         ex_seen;
      rename_lane_t ln;
      rob_ptr_t     rnum;
      sq_ptr_t      snum;
      sq_ptr_t      pnum;
      ex_seen = 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
         ln   = in_lane[src_idx_s[k]];
         rnum = rob_tail_q + ROB_PTR_W'(k);
         snum = store_tail_q + SQ_PTR_W'(st_pre_s[k]);
         pnum = snum - SQ_PTR_W'(1);
         d2i_new_s[k] = '0;
         rob_new_s[k] = '0;
         if (occ_s[k]) begin
            // an exception in this or any older lane blocks issue for the rest
            ex_seen = ex_seen | ln.exception.ex;
            d2i_new_s[k].valid           = ~ex_seen;
            d2i_new_s[k].pc              = ln.pc;
            d2i_new_s[k].inst            = ln.inst;
            d2i_new_s[k].phy_dest        = ln.phy_dest;
            d2i_new_s[k].phy_src1        = ln.phy_src1;
            d2i_new_s[k].phy_src2        = ln.phy_src2;
            d2i_new_s[k].src1_ready      = ln.src1_ready | wake_hit(ln.phy_src1, wb_valid, wb_preg);
            d2i_new_s[k].src2_ready      = ln.src2_ready | wake_hit(ln.phy_src2, wb_valid, wb_preg);
            d2i_new_s[k].rob_entry_num   = rnum[ROB_PTR_W-2:0];
            d2i_new_s[k].store_num       = snum[SQ_PTR_W-2:0];
            d2i_new_s[k].pre_store       = pnum[SQ_PTR_W-2:0];
            d2i_new_s[k].pre_store_ready = (store_head == store_tail_q) && (st_pre_s[k] == '0);
            d2i_new_s[k].is_store_op     = ln.is_store_op;
            d2i_new_s[k].is_movc         = ln.is_movc;
            d2i_new_s[k].is_priv         = ln.is_priv;
            d2i_new_s[k].is_eret         = ln.is_eret;
            d2i_new_s[k].br_taken        = ln.br_taken;
            d2i_new_s[k].bpu_entry       = ln.bpu_entry;
            rob_new_s[k].state           = ln.exception.ex ? Inst_Complete : Inst_Wait;
            rob_new_s[k].pc              = ln.pc;
            rob_new_s[k].dest            = ln.inst.rf_we ? ln.inst.dest : 5'd0;
            rob_new_s[k].phy_dest        = ln.phy_dest;
            rob_new_s[k].old_dest        = ln.old_dest;
            rob_new_s[k].is_store_op     = ln.is_store_op;
            rob_new_s[k].is_priv         = ln.is_priv;
            rob_new_s[k].is_eret         = ln.is_eret;
            rob_new_s[k].br_taken        = ln.br_taken;
            rob_new_s[k].bpu_entry       = ln.bpu_entry;
            rob_new_s[k].exception       = ln.exception;
            rob_new_s[k].verify_result   = 32'd0;
         end else begin
            rob_new_s[k].state = Inst_Invalid;
         end
      end
   end

   // Next state: flush beats accept, accept beats consume, otherwise hold with wakeup
   always_comb begin
      out_valid_d  = out_valid_q;
      cnt_d        = cnt_q;
      d2i_d        = d2i_q;
      rob_d        = rob_q;
      rob_tail_d   = rob_tail_q;
      store_tail_d = store_tail_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         rob_tail_d   = flush_rob_tail;
         store_tail_d = flush_store_tail;
      end else if (accept_s) begin
         out_valid_d  = (n_s != '0);
         cnt_d        = n_s;
         d2i_d        = d2i_new_s;
         rob_d        = rob_new_s;
         rob_tail_d   = rob_tail_q + ROB_PTR_W'(n_s);
         store_tail_d = store_tail_q + SQ_PTR_W'(s_s);
      end else if (out_accept) begin
         out_valid_d = 1'b0;
      end else if (out_valid_q) begin
         for (int k = 0; k < WIDTH; k++) begin
            d2i_d[k].src1_ready = d2i_q[k].src1_ready | wake_hit(d2i_q[k].phy_src1, wb_valid, wb_preg);
            d2i_d[k].src2_ready = d2i_q[k].src2_ready | wake_hit(d2i_q[k].phy_src2, wb_valid, wb_preg);
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         cnt_q        <= '0;
         d2i_q        <= '0;
         rob_q        <= '0;
         rob_tail_q   <= '0;
         store_tail_q <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         cnt_q        <= cnt_d;
         d2i_q        <= d2i_d;
         rob_q        <= rob_d;
         rob_tail_q   <= rob_tail_d;
         store_tail_q <= store_tail_d;
      end
   end

   assign out_valid           = out_valid_q;
   assign out_cnt             = cnt_q;
   assign decode_to_issue_bus = d2i_q;
   assign map_to_rob_bus      = rob_q;

endmodule

// File: doc/inst_dispatch_n.md
Name: inst_dispatch_n

Overview:
- N-wide registered dispatch stage between rename and the issue queue / ROB.
- Compacts valid rename lanes and allocates ROB entry numbers and store-queue numbers from speculative tail pointers that this block owns.
- Checks ROB and store-queue capacity for the whole group (all-or-nothing).
- Holds the dispatched group under back-pressure, snooping writeback wakeups so held source-ready bits stay current.
- Restores its tails on pipeline flush.

Parameters:
- WIDTH, 2, dispatch lanes per group.
- ROB_DEPTH, 16, ROB entries (power of two).
- SQ_DEPTH, 16, store-queue entries (power of two).
- WB_PORTS, 2, writeback wakeup ports snooped.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  pipeline flush
- flush_rob_tail  in  log2(ROB_DEPTH)+1  ROB tail to restore on flush
- flush_store_tail  in  log2(SQ_DEPTH)+1  SQ tail to restore on flush
- rob_head  in  log2(ROB_DEPTH)+1  committed ROB head, with wrap bit
- store_head  in  log2(SQ_DEPTH)+1  SQ head, with wrap bit
- in_valid  in  1  rename group valid
- in_ready  out  1  group accepted this cycle when in_valid is also high
- in_lane  in  WIDTH x rename_lane_t  per-lane valid, pc, inst, phy regs, src readies, old_dest, store/movc/priv/eret flags, br_taken, bpu_entry, exception
- wb_valid  in  WB_PORTS  wakeup valid
- wb_preg  in  WB_PORTS x reg_addr_t  woken physical register
- out_valid  out  1  registered group valid
- out_accept  in  1  issue queue and ROB consume the group this cycle
- decode_to_issue_bus  out  WIDTH x decode_to_issue_bus_t  issue-queue lanes
- map_to_rob_bus  out  WIDTH x rob_entry_t  ROB lanes
- out_cnt  out  log2(WIDTH)+1  number of occupied output lanes

Behaviour:

Reset:
- out_valid=0, all output lanes 0.
- Internal rob_tail=0, store_tail=0, so in_ready=1.

Capacity:
- n = popcount(in_lane.valid); s = popcount(valid & is_store_op).
- rob_occ = rob_tail - rob_head, using the wrap bit; sq_occ likewise.
- room = (rob_occ + n <= ROB_DEPTH) && (sq_occ + s <= SQ_DEPTH).
- in_ready = !flush && room && (!out_valid || out_accept).

Accept (in_valid && in_ready):
- Valid lanes are compacted in order to output lanes 0..n-1; the remaining lanes are zeroed.
- Lane k gets rob_entry_num = rob_tail + k, modulo 2*ROB_DEPTH; the low bits are exposed.
- For store prefix count p_k (older valid stores in the group):
  - store_num = store_tail + p_k
  - pre_store = store_num - 1
  - pre_store_ready = (store_head == store_tail) && p_k == 0
- Issue lane valid = 1 unless that lane, or any older lane in the group, has exception.ex.
- ROB lane state = Inst_Complete if exception.ex, else Inst_Wait. Lanes past n are Inst_Invalid.
- ROB lane dest = inst.dest if rf_we, else 0.
- ROB lane verify_result = 0.
- The registered outputs appear the next cycle (latency 1). out_valid=1, out_cnt=n.
- rob_tail += n and store_tail += s in the same cycle.
- A group with n=0 is accepted, leaves the tails unchanged, and produces out_valid=0.

Hold:
- While out_valid && !out_accept, the outputs stay stable except the wakeup update below.
- Wakeup: if wb_valid[j] && wb_preg[j]==phy_src{1,2}, set the matching src_ready, on the held register and also on incoming lanes being latched.
- Physical register 0 is never woken.

Consume:
- out_accept with no new accept sets out_valid=0 next cycle.
- Accept and consume in the same cycle replace the register back-to-back.

Flush:
- Next cycle: out_valid=0, rob_tail=flush_rob_tail, store_tail=flush_store_tail.
- Flush wins over a simultaneous accept; the group is dropped and the tails are not advanced.

Reset mid-hold: the held group is discarded.

Wrap-around: pointer arithmetic wraps naturally at 2*DEPTH; the full condition relies on the wrap bit.

Decomposition:
- Package additions to the shared CPU package:
  - rename_lane_t
  - ROB_PTR_W = $clog2(ROB_DEPTH)+1 and SQ_PTR_W
- Reuse the existing decode_to_issue_bus_t, rob_entry_t and inst state enum.
- One sub-module, dispatch_compact: a combinational prefix-count and compaction network returning per-lane source index, valid-prefix index and store-prefix count.

Test Plan:
1. Reset, then group with lanes {valid, store}, {valid, ALU}, rob_tail=0, store_tail=0 → next cycle rob_entry_num 0,1; store_num 0; lane 0 pre_store_ready=1; out_cnt=2; tails become 2 and 1.
2. Lane 0 invalid, lane 1 valid → output lane 0 carries inst 1 with rob_entry_num=tail; lane 1 is zero/Inst_Invalid; out_cnt=1.
3. Lane 0 exception.ex=1 → lane 0 ROB state Inst_Complete; both issue valids 0; lane 1 ROB state Inst_Wait; rob_tail advances by 2.
4. rob_head=0, rob_tail=15 (ROB_DEPTH=16), 2-lane group → in_ready=0. Then rob_head=1 → accepted; entries 15 and 0; rob_tail=17.
5. Hold with out_accept=0 for 3 cycles; wb_valid[0] with wb_preg = lane 0 phy_src2 → lane 0 src2_ready rises the next cycle; all other fields stable.
6. flush with flush_rob_tail=5 while in_valid=1 → group dropped; out_valid=0; the next accepted group starts at rob_entry_num 5.
